fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the fifo (WIDTH x DEPTH) between N_REQ requesters.
//  - Round-robin arbitration, with optional burst locking: the winner keeps the port for up to MAX_BURST beats.
//  - Sits directly in front of fifo.wr_en/din and is back-pressured by fifo.full.
//  - Each requester uses a valid/ready handshake.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

    localparam int STAT_W = 16;

    // Lock-valid encoding: LOCKED means a burst owner currently holds the port.
    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after start, modulo N.
module fifo_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] pos;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // Rotate so start lands at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        rot   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = valid[wrap_add(start, i)];
        end
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = IDX_W'(i);
            end
        end
        idx = wrap_add(start, int'(pos));
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the single fifo write port.
// Optional per-requester grant and stall statistics under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int N_REQ     = 4,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = idx_w(N_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_din,
    output logic [IDX_W-1:0]       owner_id,
    output logic                   lock_active
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] grant_cnt,
    output logic [STAT_W-1:0]       stall_cnt
`endif
);

    // Handshake: beat i moves when req_valid[i] && req_ready[i]; ready never
    // depends on that cycle's transfer, and at most one ready bit is high.

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             locked;
    logic             own_valid;
    logic             hold_owner;
    logic [IDX_W-1:0] after_owner;
    logic [IDX_W-1:0] scan_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             cand_found;
    logic [IDX_W-1:0] cand;
    logic             grant;
    logic [CNT_W-1:0] cnt_new;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign locked      = (state_q == ARB_LOCKED);
    assign own_valid   = req_valid[owner_q];
    assign hold_owner  = locked && own_valid;
    assign after_owner = next_idx(owner_q);
    // A lock whose owner went idle releases this cycle; scanning from owner+1 avoids a bubble.
    assign scan_start  = locked ? after_owner : rr_ptr_q;

    fifo_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (req_valid),
        .start (scan_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cand_found = hold_owner || pick_found;
    assign cand       = hold_owner ? owner_q : pick_idx;
    assign grant      = rst && cand_found && !fifo_full;

    always_comb begin
        req_ready = '0;
        fifo_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && (cand == IDX_W'(i))) begin
                req_ready[i] = 1'b1;
                fifo_din     = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_wr_en  = grant;
    assign owner_id    = owner_q;
    assign lock_active = locked;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        cnt_new    = '0;
        if (grant) begin
            if (hold_owner) begin
                cnt_new = beat_cnt_q + 1'b1;
            end else begin
                cnt_new = CNT_W'(1);
                owner_d = cand;
                if (locked) rr_ptr_d = after_owner;
            end
            state_d    = ARB_LOCKED;
            beat_cnt_d = cnt_new;
            if (cnt_new == CNT_W'(MAX_BURST)) begin
                state_d    = ARB_UNLOCKED;
                beat_cnt_d = '0;
                rr_ptr_d   = next_idx(cand);
            end
        end else if (!fifo_full && locked && !own_valid) begin
            state_d    = ARB_UNLOCKED;
            beat_cnt_d = '0;
            rr_ptr_d   = after_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_UNLOCKED;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*STAT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [STAT_W-1:0]       stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i] && (grant_cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                grant_cnt_d[i*STAT_W +: STAT_W] = grant_cnt_q[i*STAT_W +: STAT_W] + 1'b1;
            end
        end
        if (cand_found && fifo_full && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4, WIDTH=8) with a 16-deep fifo model.
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int DEPTH = 16;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_din;
    logic [1:0]             owner_id;
    logic                   lock_active;
`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*16-1:0]    grant_cnt;
    logic [15:0]            stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mem_q[$];

    fifo_wr_arbiter #(
        .WIDTH     (WIDTH),
        .N_REQ     (N_REQ),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .owner_id    (owner_id),
        .lock_active (lock_active)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] din_of(input logic [N_REQ-1:0] onehot);
        logic [WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (onehot[i]) d = 8'hA0 + WIDTH'(i);
        end
        return d;
    endfunction

    function automatic logic [N_REQ-1:0] oh(input int i);
        logic [N_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // One cycle: drive on the falling edge, check combinational grant 1 ns later.
    task automatic cyc(input logic r, input logic [N_REQ-1:0] v, input logic f,
                       input logic [N_REQ-1:0] er, input string tag);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        fifo_full = f;
        #1;
        check({tag, "_rdy"}, 32'(req_ready), 32'(er));
        check({tag, "_wr"},  32'(fifo_wr_en), 32'(|er));
        check({tag, "_din"}, 32'(fifo_din), 32'(din_of(er)));
    endtask

    task automatic chk_state(input logic [1:0] own, input logic lk, input string tag);
        check({tag, "_owner"}, 32'(owner_id), 32'(own));
        check({tag, "_lock"},  32'(lock_active), 32'(lk));
    endtask

    initial begin
        logic [N_REQ-1:0] v;
        logic             f;
        int               widx;
        rst       = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // 1: reset masks grants even with every requester valid
        cyc(1'b0, 4'hF, 1'b0, 4'b0000, "t1_rst0");
        cyc(1'b0, 4'hF, 1'b0, 4'b0000, "t1_rst1");
        chk_state(2'd0, 1'b0, "t1_rst");

        // 2: all valid -> 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0
        for (int k = 0; k <= 16; k++) begin
            cyc(1'b1, 4'hF, 1'b0, oh((k / 4) % 4), $sformatf("t2_k%0d", k));
            if (k == 1) chk_state(2'd0, 1'b1, "t1_after_first");
            if (k == 4) chk_state(2'd0, 1'b0, "t2_burst_end");
            if (k == 13) chk_state(2'd3, 1'b1, "t2_owner3");
        end

        // 3: req0 drops after 2 beats, req2 takes over with no bubble
        cyc(1'b0, 4'b0000, 1'b0, 4'b0000, "t3_rst");
        cyc(1'b1, 4'b0101, 1'b0, 4'b0001, "t3_b0");
        cyc(1'b1, 4'b0101, 1'b0, 4'b0001, "t3_b1");
        cyc(1'b1, 4'b0100, 1'b0, 4'b0100, "t3_sw");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, "t3_idle0");
        chk_state(2'd2, 1'b1, "t3_own2");
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, "t3_idle1");
        chk_state(2'd2, 1'b0, "t3_rel");
        cyc(1'b1, 4'b1111, 1'b0, 4'b1000, "t3_ptr3");

        // 4: stall mid-burst keeps the lock
        cyc(1'b0, 4'b0000, 1'b0, 4'b0000, "t4_rst");
        cyc(1'b1, 4'b0010, 1'b0, 4'b0010, "t4_b1");
        cyc(1'b1, 4'b0010, 1'b0, 4'b0010, "t4_b2");
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 4'b0110, 1'b1, 4'b0000, $sformatf("t4_full%0d", k));
            chk_state(2'd1, 1'b1, $sformatf("t4_hold%0d", k));
        end
        cyc(1'b1, 4'b0110, 1'b0, 4'b0010, "t4_b3");
        cyc(1'b1, 4'b0110, 1'b0, 4'b0010, "t4_b4");
        cyc(1'b1, 4'b0110, 1'b0, 4'b0100, "t4_rot");

        // 5: random traffic into a 16-deep fifo model with scoreboard on dout
        cyc(1'b0, 4'b0000, 1'b0, 4'b0000, "t5_rst");
        for (int c = 0; c < 500; c++) begin
            v = 4'($urandom_range(0, 15));
            f = (mem_q.size() == DEPTH);
            @(negedge clk);
            rst       = 1'b1;
            req_valid = v;
            fifo_full = f;
            #1;
            check("t5_full_wr", 32'(fifo_wr_en && fifo_full), 32'd0);
            check("t5_onehot", 32'($countones(req_ready) > 1), 32'd0);
            check("t5_wr_or", 32'(fifo_wr_en), 32'(|req_ready));
            check("t5_ready_valid", 32'(req_ready & ~v), 32'd0);
            check("t5_nobubble", 32'(fifo_wr_en), 32'((|v) && !f));
            if (fifo_wr_en) begin
                widx = 0;
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) widx = i;
                exp_q.push_back(8'hA0 + WIDTH'(widx));
                mem_q.push_back(fifo_din);
            end
            if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                check("t5_dout", 32'(mem_q.pop_front()), 32'(exp_q.pop_front()));
            end
        end
        while (mem_q.size() > 0) begin
            check("t5_drain", 32'(mem_q.pop_front()), 32'(exp_q.pop_front()));
        end

`ifdef FIFO_ARB_STATS_EN
        // 6: statistics counters
        cyc(1'b0, 4'b0000, 1'b0, 4'b0000, "t6_rst");
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, 4'hF, 1'b0, oh((k / 4) % 4), $sformatf("t6_k%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 4'hF, 1'b1, 4'b0000, $sformatf("t6_full%0d", k));
            if (k == 0) begin
                for (int i = 0; i < N_REQ; i++) begin
                    check($sformatf("t6_gcnt%0d", i), 32'(grant_cnt[i*16 +: 16]), 32'd16);
                end
                check("t6_stall0", 32'(stall_cnt), 32'd0);
            end
        end
        cyc(1'b1, 4'hF, 1'b0, 4'b0001, "t6_resume");
        check("t6_stall5", 32'(stall_cnt), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
